// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the MIPS core: captures decoded operands, detects
// load-use hazards and inserts bubbles, honours EX stalls and branch/jump flushes.
module id_ex_stage #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [9:0]       id_ctrl,
   input  logic [WIDTH-1:0] id_rd1,
   input  logic [WIDTH-1:0] id_rd2,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic [WIDTH-1:0] id_imm,
   input  logic [WIDTH-1:0] id_pcplus4,
   input  logic             flush,
   input  logic             ex_stall,
   output logic             ex_valid,
   output logic [9:0]       ex_ctrl,
   output logic [WIDTH-1:0] ex_rd1,
   output logic [WIDTH-1:0] ex_rd2,
   output logic [WIDTH-1:0] ex_imm,
   output logic [WIDTH-1:0] ex_pcplus4,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_rd,
   output logic             stall_id,
   output logic [CNT_W-1:0] bubble_count
);

   localparam int CTRL_REGDST   = 8;
   localparam int CTRL_BR_HI    = 6;
   localparam int CTRL_BR_LO    = 5;
   localparam int CTRL_MEMWRITE = 4;
   localparam int CTRL_MEMTOREG = 3;

   logic             valid_q,   valid_d;
   logic [9:0]       ctrl_q,    ctrl_d;
   logic [WIDTH-1:0] rd1_q,     rd1_d;
   logic [WIDTH-1:0] rd2_q,     rd2_d;
   logic [WIDTH-1:0] imm_q,     imm_d;
   logic [WIDTH-1:0] pcplus4_q, pcplus4_d;
   logic [4:0]       rs_q,      rs_d;
   logic [4:0]       rt_q,      rt_d;
   logic [4:0]       rd_q,      rd_d;
   logic [CNT_W-1:0] bcnt_q,    bcnt_d;

   logic uses_rt;
   logic hazard;

   // rt is a source for R-type, stores and compare-branches; ADDI/LW only write it.
   always_comb begin
      uses_rt = id_ctrl[CTRL_REGDST] | id_ctrl[CTRL_MEMWRITE] |
                (id_ctrl[CTRL_BR_HI:CTRL_BR_LO] != 2'b00);
      hazard  = valid_q & ctrl_q[CTRL_MEMTOREG] & (rt_q != 5'd0) & id_valid &
                ((rt_q == id_rs) | (uses_rt & (rt_q == id_rt)));
      stall_id = ~reset & ~flush & (ex_stall | hazard);
   end

   always_comb begin
      // NOTE: every _d gets a default (hold) first, so no path infers a latch.
      valid_d   = valid_q;
      ctrl_d    = ctrl_q;
      rd1_d     = rd1_q;
      rd2_d     = rd2_q;
      imm_d     = imm_q;
      pcplus4_d = pcplus4_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rd_d      = rd_q;
      bcnt_d    = bcnt_q;
      if (reset || flush || (!ex_stall && hazard)) begin
         // Reset and both kinds of bubble clear the payload; only reset clears the counter.
         valid_d   = 1'b0;
         ctrl_d    = '0;
         rd1_d     = '0;
         rd2_d     = '0;
         imm_d     = '0;
         pcplus4_d = '0;
         rs_d      = '0;
         rt_d      = '0;
         rd_d      = '0;
         if (reset) begin
            bcnt_d = '0;
         end else if (!flush && (bcnt_q != {CNT_W{1'b1}})) begin
            bcnt_d = bcnt_q + CNT_W'(1);
         end
      end else if (!ex_stall) begin
         valid_d   = id_valid;
         ctrl_d    = id_ctrl;
         rd1_d     = id_rd1;
         rd2_d     = id_rd2;
         imm_d     = id_imm;
         pcplus4_d = id_pcplus4;
         rs_d      = id_rs;
         rt_d      = id_rt;
         rd_d      = id_rd;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      imm_q     <= imm_d;
      pcplus4_q <= pcplus4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      bcnt_q    <= bcnt_d;
   end

   assign ex_valid     = valid_q;
   assign ex_ctrl      = ctrl_q;
   assign ex_rd1       = rd1_q;
   assign ex_rd2       = rd2_q;
   assign ex_imm       = imm_q;
   assign ex_pcplus4   = pcplus4_q;
   assign ex_rs        = rs_q;
   assign ex_rt        = rt_q;
   assign ex_rd        = rd_q;
   assign bubble_count = bcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued as each ID
// instruction is driven and compared after the following clock edge.
module tb_id_ex_stage;

   localparam logic [9:0] C_ADDI = 10'b1010000000;
   localparam logic [9:0] C_RTYP = 10'b1100000010;
   localparam logic [9:0] C_LW   = 10'b1010001000;
   localparam logic [9:0] C_SW   = 10'b0010010000;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [9:0]  id_ctrl;
   logic [31:0] id_rd1, id_rd2, id_imm, id_pcplus4;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        flush, ex_stall;

   logic        ex_valid, stall_id;
   logic [9:0]  ex_ctrl;
   logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pcplus4;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [15:0] bubble_count;

   logic        s_ex_valid, s_stall_id;
   logic [9:0]  s_ex_ctrl;
   logic [31:0] s_ex_rd1, s_ex_rd2, s_ex_imm, s_ex_pcplus4;
   logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
   logic [1:0]  s_bubble_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        valid;
      logic [9:0]  ctrl;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd;
      logic [15:0] bcnt;
      logic [1:0]  bsat;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   exp_bcnt = 0;
   int   exp_bsat = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_imm(id_imm), .id_pcplus4(id_pcplus4), .flush(flush), .ex_stall(ex_stall),
      .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_pcplus4(ex_pcplus4), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .stall_id(stall_id), .bubble_count(bubble_count)
   );

   id_ex_stage #(.WIDTH(32), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_imm(id_imm), .id_pcplus4(id_pcplus4), .flush(flush), .ex_stall(ex_stall),
      .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
      .ex_imm(s_ex_imm), .ex_pcplus4(s_ex_pcplus4), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
      .ex_rd(s_ex_rd), .stall_id(s_stall_id), .bubble_count(s_bubble_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // flush together with ex_stall is a protocol violation by the environment.
   always @(negedge clk) begin
      n_checks++;
      assert (!(flush && ex_stall))
      else begin
         n_errors++;
         $error("FAIL protocol: observed flush=%b ex_stall=%b expected not both", flush, ex_stall);
      end
   end

   task automatic set_id(input logic valid, input logic [9:0] ctrl, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
      id_valid   = valid;
      id_ctrl    = ctrl;
      id_rs      = rs;
      id_rt      = rt;
      id_rd      = rd;
      id_imm     = imm;
      id_rd1     = $urandom;
      id_rd2     = $urandom;
      id_pcplus4 = id_pcplus4 + 32'd4;
   endtask

   task automatic stall_check(input logic expv);
      #1;
      check("stall_id", 32'(stall_id), 32'(expv));
   endtask

   task automatic push_load();
      exp_t e;
      e.valid = id_valid;  e.ctrl = id_ctrl;
      e.rd1 = id_rd1;      e.rd2 = id_rd2;  e.imm = id_imm;  e.pc4 = id_pcplus4;
      e.rs = id_rs;        e.rt = id_rt;    e.rd = id_rd;
      e.bcnt = 16'(exp_bcnt);
      e.bsat = 2'(exp_bsat);
      exp_q.push_back(e);
      last_exp = e;
   endtask

   task automatic push_bubble(input bit counted);
      exp_t e;
      if (counted) begin
         exp_bcnt++;
         if (exp_bsat < 3) exp_bsat++;
      end
      e.valid = 1'b0;  e.ctrl = '0;
      e.rd1 = '0;  e.rd2 = '0;  e.imm = '0;  e.pc4 = '0;
      e.rs = '0;   e.rt = '0;   e.rd = '0;
      e.bcnt = 16'(exp_bcnt);
      e.bsat = 2'(exp_bsat);
      exp_q.push_back(e);
      last_exp = e;
   endtask

   task automatic push_hold();
      exp_q.push_back(last_exp);
   endtask

   task automatic clock_and_compare();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end else begin
         e = exp_q.pop_front();
         check("ex_valid",     32'(ex_valid),       32'(e.valid));
         check("ex_ctrl",      32'(ex_ctrl),        32'(e.ctrl));
         check("ex_rd1",       ex_rd1,              e.rd1);
         check("ex_rd2",       ex_rd2,              e.rd2);
         check("ex_imm",       ex_imm,              e.imm);
         check("ex_pcplus4",   ex_pcplus4,          e.pc4);
         check("ex_rs",        32'(ex_rs),          32'(e.rs));
         check("ex_rt",        32'(ex_rt),          32'(e.rt));
         check("ex_rd",        32'(ex_rd),          32'(e.rd));
         check("bubble_count", 32'(bubble_count),   32'(e.bcnt));
         check("sat_count",    32'(s_bubble_count), 32'(e.bsat));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      id_pcplus4 = 32'h0000_0100;
      flush      = 1'b0;

      // Reset with ex_stall high: reset wins and stall_id stays low.
      reset = 1'b1;  ex_stall = 1'b1;
      set_id(1'b0, '0, 5'd0, 5'd0, 5'd0, 32'd0);
      stall_check(1'b0);
      push_bubble(1'b0);
      clock_and_compare();

      // Straight-line ADDI then R-type.
      reset = 1'b0;  ex_stall = 1'b0;
      set_id(1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'd5);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_RTYP, 5'd3, 5'd4, 5'd5, 32'd0);
      stall_check(1'b0);  push_load();  clock_and_compare();

      // Load-use via rs: one bubble, then the consumer enters EX.
      set_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'd4);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_RTYP, 5'd8, 5'd9, 5'd10, 32'd0);
      stall_check(1'b1);  push_bubble(1'b1);  clock_and_compare();
      stall_check(1'b0);  push_load();  clock_and_compare();

      // No false hazard: LW rt=0 vs rs=0, and ADDI whose rt is a destination.
      set_id(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 32'd8);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_RTYP, 5'd0, 5'd0, 5'd11, 32'd0);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'd12);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_ADDI, 5'd3, 5'd8, 5'd0, 32'hFFFF_FFF0);
      stall_check(1'b0);  push_load();  clock_and_compare();

      // Invalid ID matching a load's rt: no hazard, ctrl copied verbatim.
      set_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'd16);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b0, C_RTYP, 5'd8, 5'd8, 5'd12, 32'd0);
      stall_check(1'b0);  push_load();  clock_and_compare();

      // Load-use via rt on a store.
      set_id(1'b1, C_LW, 5'd1, 5'd7, 5'd0, 32'd20);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_SW, 5'd1, 5'd7, 5'd0, 32'd24);
      stall_check(1'b1);  push_bubble(1'b1);  clock_and_compare();
      stall_check(1'b0);  push_load();  clock_and_compare();

      // EX stall for 3 cycles with a pending hazard, then flush.
      set_id(1'b1, C_LW, 5'd1, 5'd6, 5'd0, 32'd28);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_RTYP, 5'd6, 5'd2, 5'd13, 32'd0);
      ex_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stall_check(1'b1);  push_hold();  clock_and_compare();
      end
      ex_stall = 1'b0;  flush = 1'b1;
      stall_check(1'b0);  push_bubble(1'b0);  clock_and_compare();
      flush = 1'b0;

      // Reset arriving during a held stall.
      set_id(1'b1, C_LW, 5'd1, 5'd6, 5'd0, 32'd32);
      stall_check(1'b0);  push_load();  clock_and_compare();
      set_id(1'b1, C_RTYP, 5'd6, 5'd3, 5'd14, 32'd0);
      ex_stall = 1'b1;
      stall_check(1'b1);  push_hold();  clock_and_compare();
      reset = 1'b1;
      stall_check(1'b0);
      exp_bcnt = 0;  exp_bsat = 0;
      push_bubble(1'b0);  clock_and_compare();
      reset = 1'b0;  ex_stall = 1'b0;

      // Five load-use pairs: 16-bit counter reaches 5, 2-bit counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'(i));
         stall_check(1'b0);  push_load();  clock_and_compare();
         set_id(1'b1, C_RTYP, 5'd5, 5'd1, 5'd2, 32'd0);
         stall_check(1'b1);  push_bubble(1'b1);  clock_and_compare();
         stall_check(1'b0);  push_load();  clock_and_compare();
      end
      check("bubble_count_final", 32'(bubble_count), 32'd5);
      check("sat_count_final", 32'(s_bubble_count), 32'd3);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage of the pipelined MIPS core.
- Captures the main decoder's 10-bit control word, register-file operands, register specifiers, sign-extended immediate and PC+4 at the end of ID, and presents them to EX one cycle later.
- Owns load-use hazard detection: inserts a bubble and stalls IF/ID.
- Also honours downstream stalls and branch/jump flushes.

Parameters:
- WIDTH, 32, datapath width of operands, immediate and PC+4.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  10  decoder word {regwrite, regdst, alusrc, branch[1:0], memwrite, memtoreg, jump, aluop[1:0]}, bit 9 = regwrite.
- id_rd1, id_rd2  in  WIDTH  register-file read data.
- id_rs, id_rt, id_rd  in  5  register specifiers.
- id_imm  in  WIDTH  sign-extended immediate.
- id_pcplus4  in  WIDTH  PC+4 of ID instruction.
- flush  in  1  EX resolved a taken branch/jump; ID instruction is wrong-path.
- ex_stall  in  1  EX/MEM cannot accept a new instruction this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  10  registered control word, same bit order as id_ctrl.
- ex_rd1, ex_rd2, ex_imm, ex_pcplus4  out  WIDTH  registered copies.
- ex_rs, ex_rt, ex_rd  out  5  registered copies.
- stall_id  out  1  combinational; IF/ID and PC must hold.
- bubble_count  out  CNT_W  load-use bubbles inserted since reset.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: every registered output is 0 (ex_valid, ex_ctrl, all data/specifier fields, bubble_count). Reset asserted mid-operation discards the held instruction and yields zeros on the next edge; stall_id is 0 while reset is high.
- uses_rt: id_ctrl.regdst | id_ctrl.memwrite | (id_ctrl.branch != 0). This covers R-type, SW, BEQ and BLT.
- hazard: all of the following hold:
  - ex_valid & ex_ctrl.memtoreg & (ex_rt != 0) & id_valid
  - and either (ex_rt == id_rs) or (uses_rt & ex_rt == id_rt).
- stall_id = ~reset & ~flush & (ex_stall | hazard).
- Per-edge update, first matching row wins:
  1. reset -> zeros.
  2. flush -> load bubble.
  3. ex_stall -> hold all registers unchanged.
  4. hazard -> load bubble; bubble_count++.
  5. otherwise -> load all id_* fields; ex_valid <= id_valid.
- Bubble: ex_valid=0, ex_ctrl=0 (no regwrite/memwrite/branch/jump), all data and specifier fields 0.
- flush is only raised when ex_stall=0. flush & ex_stall together is a protocol error: the bench asserts it never occurs; RTL behaviour follows priority.
- Invalid ID (id_valid=0) passes with its ctrl copied verbatim. EX must qualify side effects with ex_valid. The hazard check never fires for it.
- Latency: exactly 1 cycle ID->EX when unstalled. A load-use pair costs exactly one bubble: after the bubble, the load has left EX and hazard drops.
- bubble_count: increments only on row 4 (not on flush bubbles); saturates at 2^CNT_W-1.

Test Plan:
- Straight-line: ADDI ctrl 10'b1010000000, rs=1, rt=2, imm=5, valid, then R-type ctrl 10'b1100000010 -> each appears on ex_* one edge later; stall_id=0; bubble_count=0.
- Load-use: EX holds LW (ctrl 10'b1010001000, rt=8); ID holds R-type with rs=8 -> stall_id=1 that cycle; next edge ex_valid=0, ex_ctrl=0, bubble_count=1; following edge the R-type enters EX.
- No false hazard: EX LW rt=0 with ID rs=0 -> no stall. EX LW rt=8 with ID ADDI rt=8 (rt not a source) -> no stall.
- Stall vs flush: ex_stall=1 for 3 cycles -> registers frozen, stall_id=1. Then flush=1 with hazard also true -> bubble loaded, stall_id=0, bubble_count unchanged.
- Reset mid-stream: reset during a held stall -> next edge all outputs 0, stall_id=0.
- Saturation: CNT_W=2, force 5 load-use hazards -> bubble_count ends at 3.
